syst_feeder: RTL and testbench

//  Upstream sequencer for the 4x4 systolic-array wrapper. Accepts one 32-bit beat stream over valid/ready.

---
 rtl/syst_feeder_pkg.sv | 8 +
 rtl/syst_feeder_if.sv | 23 ++
 rtl/syst_feeder.sv | 133 +++++++++++++
 tb/tb_syst_feeder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/syst_feeder_pkg.sv
// Shared types and constants for the systolic-array feeder and its stream interface.
package syst_pkg;
  localparam int SYST_WORD = 32;
  localparam int SYST_ROWS = 4;
  localparam int SYST_X_W  = 8;

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} feeder_state_t;
endpackage

// File: rtl/syst_feeder_if.sv
// Beat stream from the host plus the wrapper-facing strobes and result-valid return.
interface syst_feeder_if import syst_pkg::*; #(
  parameter int WORD = SYST_WORD,
  parameter int ROWS = SYST_ROWS
);
  logic [WORD-1:0] s_data_i;
  logic            s_valid_i;
  logic            s_ready_o;
  logic [WORD-1:0] data_o;
  logic            valid_o;
  logic [ROWS-1:0] valid_raw_o;
  logic            res_valid_i;

  modport master (
    output s_data_i, s_valid_i, res_valid_i,
    input  s_ready_o, data_o, valid_o, valid_raw_o
  );

  modport slave (
    input  s_data_i, s_valid_i, res_valid_i,
    output s_ready_o, data_o, valid_o, valid_raw_o
  );
endinterface

// File: rtl/syst_feeder.sv
// Sequencer feeding weight rows and activation vectors into the 4x4 systolic wrapper,
// counting returned results and flagging completion or drain timeout.
module syst_feeder import syst_pkg::*; #(
  parameter int WORD      = SYST_WORD,
  parameter int ROWS      = SYST_ROWS,
  parameter int NVEC_W    = 5,
  parameter int DRAIN_MAX = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              load_w_i,
  input  logic [NVEC_W-1:0] num_vec_i,
  syst_feeder_if.slave      bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DRN_W = $clog2(DRAIN_MAX + 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_MAX - 1);

  feeder_state_t state_q, state_d;
  logic [NVEC_W-1:0] n_q, n_d, vec_cnt_q, vec_cnt_d, res_cnt_q, res_cnt_d, res_next;
  logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
  logic [DRN_W-1:0]  drn_cnt_q, drn_cnt_d;
  logic [WORD-1:0]   data_q;
  logic              valid_q, done_q, err_q;
  logic [ROWS-1:0]   raw_q;
  logic              in_idle, in_load, in_stream, in_drain, s_ready;
  logic              acc, start_ok, res_inc, done_hit, tout_hit;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = load_w_i ? LOAD_W : STREAM;
      LOAD_W:  if (acc && row_cnt_q == ROW_LAST) state_d = STREAM;
      STREAM:  if (acc && vec_cnt_q == n_q - NVEC_W'(1)) state_d = DRAIN;
      DRAIN:   if (done_hit || tout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_idle   = (state_q == IDLE);
    in_load   = (state_q == LOAD_W);
    in_stream = (state_q == STREAM);
    in_drain  = (state_q == DRAIN);
    s_ready   = in_load || (in_stream && vec_cnt_q < n_q);
  end

  assign acc      = bus.s_valid_i && s_ready;
  assign start_ok = in_idle && start_i && (num_vec_i != '0);
  // Results can overtake the tail of STREAM; count them there too, but never past N.
  assign res_inc  = bus.res_valid_i && (in_stream || in_drain) && (res_cnt_q < n_q);
  assign res_next = res_cnt_q + {{(NVEC_W-1){1'b0}}, res_inc};
  assign done_hit = in_drain && (res_next == n_q);
  assign tout_hit = in_drain && !done_hit && !bus.res_valid_i && (drn_cnt_q == DRN_LAST);

  // ---------------- counters ----------------
  always_comb begin
    n_d       = n_q;
    row_cnt_d = row_cnt_q;
    vec_cnt_d = vec_cnt_q;
    res_cnt_d = res_next;
    drn_cnt_d = '0;
    if (start_ok) begin
      n_d       = num_vec_i;
      row_cnt_d = '0;
      vec_cnt_d = '0;
      res_cnt_d = '0;
    end
    if (acc && in_load)   row_cnt_d = row_cnt_q + ROW_W'(1);
    if (acc && in_stream) vec_cnt_d = vec_cnt_q + NVEC_W'(1);
    if (in_drain && !bus.res_valid_i) drn_cnt_d = drn_cnt_q + DRN_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      n_q       <= '0;
      row_cnt_q <= '0;
      vec_cnt_q <= '0;
      res_cnt_q <= '0;
      drn_cnt_q <= '0;
    end else begin
      n_q       <= n_d;
      row_cnt_q <= row_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      res_cnt_q <= res_cnt_d;
      drn_cnt_q <= drn_cnt_d;
    end
  end

  // ---------------- output register stage ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      raw_q   <= '0;
    end else begin
      if (acc) data_q <= bus.s_data_i;
      valid_q <= acc && in_stream;
      raw_q   <= (acc && in_load) ? (ROWS'(1) << row_cnt_q) : '0;
    end
  end

  // ---------------- status flags ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_hit;
      if (start_ok)      err_q <= 1'b0;
      else if (tout_hit) err_q <= 1'b1;
    end
  end

  assign bus.s_ready_o   = s_ready;
  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.valid_raw_o = raw_q;
  assign busy_o          = !in_idle;
  assign done_o          = done_q;
  assign err_o           = err_q;
endmodule

// File: tb/tb_syst_feeder.sv
// Directed bench for syst_feeder: weight load, streaming, backpressure, timeout, reset, edge starts.
module tb_syst_feeder;
  import syst_pkg::*;

  localparam int NVEC_W    = 5;
  localparam int DRAIN_MAX = 64;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              load_w;
  logic [NVEC_W-1:0] num_vec;
  logic              busy, done, err;
  int                checks = 0;
  int                errors = 0;
  logic              done_seen;

  syst_feeder_if bus ();

  syst_feeder #(.NVEC_W(NVEC_W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .start_i   (start),
    .load_w_i  (load_w),
    .num_vec_i (num_vec),
    .bus       (bus),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; load_w = 1'b0; num_vec = '0;
    bus.s_data_i = '0; bus.s_valid_i = 1'b0; bus.res_valid_i = 1'b0;
    tick();
    chk("rst_data", bus.data_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_raw", bus.valid_raw_o, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.s_ready_o, 0);
    rst_n = 1'b1;
    tick();

    // 1: full job with weight load, N=3
    start = 1; load_w = 1; num_vec = 3;
    tick();
    start = 0;
    chk("t1_busy", busy, 1);
    chk("t1_ready_load", bus.s_ready_o, 1);
    for (int k = 0; k < 4; k++) begin
      bus.s_valid_i = 1; bus.s_data_i = 32'hA0A1A200 + k;
      tick();
      chk("t1_raw", bus.valid_raw_o, 32'd1 << k);
      chk("t1_wdata", bus.data_o, 32'hA0A1A200 + k);
      chk("t1_wvalid", bus.valid_o, 0);
    end
    for (int k = 0; k < 3; k++) begin
      bus.s_data_i = 32'h11223340 + k;
      tick();
      chk("t1_xvalid", bus.valid_o, 1);
      chk("t1_xdata", bus.data_o, 32'h11223340 + k);
      chk("t1_xraw", bus.valid_raw_o, 0);
    end
    bus.s_valid_i = 0;
    chk("t1_ready_drain", bus.s_ready_o, 0);
    tick();
    chk("t1_valid_gap", bus.valid_o, 0);
    chk("t1_data_hold", bus.data_o, 32'h11223342);
    bus.res_valid_i = 1;
    tick(); chk("t1_done_r1", done, 0);
    tick(); chk("t1_done_r2", done, 0);
    tick(); chk("t1_done_r3", done, 1); chk("t1_idle", busy, 0);
    bus.res_valid_i = 0;
    tick(); chk("t1_done_pulse", done, 0);

    // 2: reuse weights, N=2, one result during STREAM
    start = 1; load_w = 0; num_vec = 2;
    tick();
    start = 0;
    chk("t2_ready", bus.s_ready_o, 1);
    bus.s_valid_i = 1; bus.s_data_i = 32'hCAFE0001;
    tick();
    chk("t2_v0", bus.valid_o, 1); chk("t2_d0", bus.data_o, 32'hCAFE0001); chk("t2_raw0", bus.valid_raw_o, 0);
    bus.s_data_i = 32'hCAFE0002; bus.res_valid_i = 1;
    tick();
    chk("t2_v1", bus.valid_o, 1); chk("t2_d1", bus.data_o, 32'hCAFE0002); chk("t2_raw1", bus.valid_raw_o, 0);
    chk("t2_ready_drain", bus.s_ready_o, 0);
    bus.s_valid_i = 0;
    tick();
    chk("t2_done", done, 1); chk("t2_valid_off", bus.valid_o, 0);
    bus.res_valid_i = 0;
    tick();
    chk("t2_done_pulse", done, 0); chk("t2_idle", busy, 0);

    // 3: backpressure, N=4 with alternating s_valid
    start = 1; load_w = 0; num_vec = 4;
    tick();
    start = 0;
    for (int i = 0; i < 8; i++) begin
      bus.s_valid_i = (i % 2 == 0); bus.s_data_i = 32'h55000000 + i;
      tick();
      chk("t3_valid", bus.valid_o, (i % 2 == 0));
      if (i % 2 == 0) chk("t3_data", bus.data_o, 32'h55000000 + i);
    end
    bus.s_valid_i = 0;
    chk("t3_ready_drain", bus.s_ready_o, 0);
    chk("t3_busy", busy, 1);
    bus.res_valid_i = 1;
    repeat (3) tick();
    chk("t3_done_early", done, 0);
    tick();
    chk("t3_done", done, 1);
    tick();
    chk("t3_extra_res", done, 0); chk("t3_idle", busy, 0);
    bus.res_valid_i = 0;

    // 4: timeout with one of two results
    start = 1; load_w = 0; num_vec = 2;
    tick();
    start = 0;
    bus.s_valid_i = 1; bus.s_data_i = 32'h0000BEE1;
    tick();
    bus.s_data_i = 32'h0000BEE2;
    tick();
    bus.s_valid_i = 0; bus.res_valid_i = 1;
    tick();
    bus.res_valid_i = 0;
    done_seen = 0;
    for (int i = 0; i < DRAIN_MAX - 1; i++) begin
      tick();
      if (done) done_seen = 1;
    end
    chk("t4_err_early", err, 0);
    chk("t4_busy_early", busy, 1);
    tick();
    if (done) done_seen = 1;
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_no_done", done_seen, 0);
    tick();
    chk("t4_err_sticky", err, 1);
    start = 1; num_vec = 0;
    tick();
    start = 0;
    chk("t4_err_zero_start", err, 1);
    chk("t4_busy_zero_start", busy, 0);
    start = 1; num_vec = 1;
    tick();
    start = 0;
    chk("t4_err_clear", err, 0);
    bus.s_valid_i = 1; bus.s_data_i = 32'h0000BEE3;
    tick();
    bus.s_valid_i = 0; bus.res_valid_i = 1;
    tick();
    chk("t4_done_after", done, 1);
    bus.res_valid_i = 0;
    tick();

    // 5: reset in the middle of STREAM
    start = 1; load_w = 0; num_vec = 4;
    tick();
    start = 0;
    bus.s_valid_i = 1; bus.s_data_i = 32'h77770001;
    tick();
    chk("t5_v0", bus.valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_data", bus.data_o, 0);
    chk("t5_rst_valid", bus.valid_o, 0);
    chk("t5_rst_raw", bus.valid_raw_o, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", bus.s_ready_o, 0);
    chk("t5_rst_err", err, 0);
    bus.s_valid_i = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t5_idle", busy, 0);
    chk("t5_valid_quiet", bus.valid_o, 0);
    start = 1; num_vec = 1;
    tick();
    start = 0;
    bus.s_valid_i = 1; bus.s_data_i = 32'h77770002;
    tick();
    chk("t5_new_valid", bus.valid_o, 1);
    chk("t5_new_data", bus.data_o, 32'h77770002);
    bus.s_valid_i = 0; bus.res_valid_i = 1;
    tick();
    chk("t5_done", done, 1);
    bus.res_valid_i = 0;
    tick();

    // 6: ignored starts and results outside STREAM/DRAIN
    start = 1; load_w = 1; num_vec = 0;
    tick();
    start = 0;
    chk("t6_zero_busy", busy, 0);
    chk("t6_zero_ready", bus.s_ready_o, 0);
    bus.res_valid_i = 1;
    tick(); tick();
    bus.res_valid_i = 0;
    start = 1; load_w = 1; num_vec = 1;
    tick();
    chk("t6_load_ready", bus.s_ready_o, 1);
    bus.res_valid_i = 1; start = 1; load_w = 0; num_vec = 5;
    for (int k = 0; k < 4; k++) begin
      bus.s_valid_i = 1; bus.s_data_i = 32'h06000000 + k;
      tick();
    end
    chk("t6_raw_last", bus.valid_raw_o, 8);
    bus.res_valid_i = 0; start = 0;
    chk("t6_stream_ready", bus.s_ready_o, 1);
    bus.s_data_i = 32'h06000010;
    tick();
    bus.s_valid_i = 0;
    chk("t6_n_kept", bus.s_ready_o, 0);
    tick();
    chk("t6_load_res_ignored", done, 0);
    chk("t6_busy", busy, 1);
    bus.res_valid_i = 1;
    tick();
    chk("t6_done", done, 1);
    bus.res_valid_i = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
